// File: rtl/leds_pkg.sv
// Shared constants for the LED output peripheral: register addresses and default sizing.
package leds_pkg;

  typedef enum logic [1:0] {
    LED_ADDR_LO     = 2'b00,
    LED_ADDR_BLK_LO = 2'b01,
    LED_ADDR_HI     = 2'b10,
    LED_ADDR_BLK_HI = 2'b11
  } led_addr_e;

  localparam int LED_W_DEF     = 24;
  localparam int BLINK_DIV_DEF = 5000000;

endpackage

// File: rtl/leds_mmio_if.sv
// CPU-side access port of the LED peripheral, as presented by the memorio decoder.
interface leds_mmio_if;
  logic        ledcs;
  logic        ledwrite;
  logic        ledread;
  logic [1:0]  ledaddr;
  logic [15:0] ledwdata;
  logic [31:0] ledrdata;
  logic        ledack;

  modport master (
    output ledcs, ledwrite, ledread, ledaddr, ledwdata,
    input  ledrdata, ledack
  );

  modport slave (
    input  ledcs, ledwrite, ledread, ledaddr, ledwdata,
    output ledrdata, ledack
  );
endinterface

// File: rtl/leds_mmio_blink_timer.sv
// Free-running blink prescaler: phase toggles every DIV falling edges of clk, starting at 1.
module blink_timer #(
  parameter int DIV = 5000000
) (
  input  logic clk,
  input  logic rst,
  output logic phase
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/leds_mmio.sv
// Memory-mapped LED output register block with registered readback and access ack.
// Define LEDS_BLINK_EN to build the per-LED blink mask and prescaler.
module leds_mmio
  import leds_pkg::*;
#(
  parameter int LED_W     = LED_W_DEF,
  parameter int BLINK_DIV = BLINK_DIV_DEF
) (
  input  logic             ledclk,
  input  logic             switrst,
  leds_mmio_if.slave       bus,
  output logic [LED_W-1:0] led_o
);

  if (LED_W < 17 || LED_W > 32 || BLINK_DIV < 2) begin : g_param_chk
    $error("leds_mmio: LED_W must be 17..32 and BLINK_DIV >= 2");
  end

  logic             wr_en;
  logic             rd_en;
  logic [31:0]      rd_val;
  logic [LED_W-1:0] led_reg;

  assign wr_en = bus.ledcs && bus.ledwrite;
  assign rd_en = bus.ledcs && bus.ledread;

`ifdef LEDS_BLINK_EN
  logic [LED_W-1:0] blink_mask;
  logic             phase;

  blink_timer #(.DIV(BLINK_DIV)) u_blink_timer (
    .clk   (ledclk),
    .rst   (switrst),
    .phase (phase)
  );

  always_ff @(negedge ledclk or posedge switrst) begin
    if (switrst) begin
      blink_mask <= '0;
    end else if (wr_en) begin
      if (bus.ledaddr == LED_ADDR_BLK_LO)
        blink_mask[15:0] <= bus.ledwdata;
      if (bus.ledaddr == LED_ADDR_BLK_HI)
        blink_mask[LED_W-1:16] <= bus.ledwdata[LED_W-17:0];
    end
  end

  // Masked LEDs go dark during the low half of the blink period.
  assign led_o = led_reg & ~(blink_mask & {LED_W{~phase}});
`else
  assign led_o = led_reg;
`endif

  always_comb begin
    rd_val = '0;
    case (bus.ledaddr)
      LED_ADDR_LO: rd_val[15:0]       = led_reg[15:0];
      LED_ADDR_HI: rd_val[LED_W-17:0] = led_reg[LED_W-1:16];
`ifdef LEDS_BLINK_EN
      LED_ADDR_BLK_LO: rd_val[15:0]       = blink_mask[15:0];
      LED_ADDR_BLK_HI: rd_val[LED_W-17:0] = blink_mask[LED_W-1:16];
`endif
      default: rd_val = '0;
    endcase
  end

  // Readback samples the pre-write register value when read and write coincide.
  always_ff @(negedge ledclk or posedge switrst) begin
    if (switrst) begin
      led_reg      <= '0;
      bus.ledrdata <= '0;
      bus.ledack   <= 1'b0;
    end else begin
      bus.ledack <= wr_en || rd_en;
      if (rd_en)
        bus.ledrdata <= rd_val;
      if (wr_en && bus.ledaddr == LED_ADDR_LO)
        led_reg[15:0] <= bus.ledwdata;
      if (wr_en && bus.ledaddr == LED_ADDR_HI)
        led_reg[LED_W-1:16] <= bus.ledwdata[LED_W-17:0];
    end
  end

endmodule

// File: tb/tb_leds_mmio.sv
// Directed self-checking bench for leds_mmio (LED_W=24, BLINK_DIV=4), with or without LEDS_BLINK_EN.
module tb_leds_mmio;
  import leds_pkg::*;

  localparam int LED_W     = 24;
  localparam int BLINK_DIV = 4;

  logic             ledclk;
  logic             switrst;
  logic [LED_W-1:0] led_o;
  int               n_assert;
  int               n_fail;

  leds_mmio_if bus ();

  leds_mmio #(.LED_W(LED_W), .BLINK_DIV(BLINK_DIV)) dut (
    .ledclk  (ledclk),
    .switrst (switrst),
    .bus     (bus.slave),
    .led_o   (led_o)
  );

  initial begin
    ledclk = 1'b1;
    forever #5 ledclk = ~ledclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_op(input logic cs, input logic wr, input logic rd,
                        input logic [1:0] addr, input logic [15:0] data);
    bus.ledcs    = cs;
    bus.ledwrite = wr;
    bus.ledread  = rd;
    bus.ledaddr  = addr;
    bus.ledwdata = data;
    @(negedge ledclk);
    #1;
    bus.ledcs    = 1'b0;
    bus.ledwrite = 1'b0;
    bus.ledread  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge ledclk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] blk_rd;
    logic [31:0] led_dark;
    n_assert     = 0;
    n_fail       = 0;
    switrst      = 1'b1;
    bus.ledcs    = 1'b0;
    bus.ledwrite = 1'b0;
    bus.ledread  = 1'b0;
    bus.ledaddr  = 2'b00;
    bus.ledwdata = 16'h0000;
    #2;
    chk("rst_led_o", 32'(led_o), 32'h0);
    chk("rst_rdata", bus.ledrdata, 32'h0);
    chk("rst_ack", 32'(bus.ledack), 32'h0);
    @(posedge ledclk);
    switrst = 1'b0;

    // Low/high writes and readback with a single-cycle ack
    bus_op(1, 1, 0, LED_ADDR_LO, 16'hA5A5);
    chk("wr_lo_ack", 32'(bus.ledack), 32'h1);
    bus_op(1, 1, 0, LED_ADDR_HI, 16'h00C3);
    chk("wr_hi_led", 32'(led_o), 32'h00C3A5A5);
    bus_op(1, 0, 1, LED_ADDR_HI, 16'h0000);
    chk("rd_hi_data", bus.ledrdata, 32'h000000C3);
    chk("rd_hi_ack", 32'(bus.ledack), 32'h1);
    idle(1);
    chk("ack_drop", 32'(bus.ledack), 32'h0);
    chk("rdata_hold", bus.ledrdata, 32'h000000C3);

    // Excess high-half bits are dropped
    bus_op(1, 1, 0, LED_ADDR_HI, 16'hFF3C);
    chk("hi_trunc_led", 32'(led_o), 32'h003CA5A5);
    bus_op(1, 0, 1, LED_ADDR_HI, 16'h0000);
    chk("hi_trunc_rd", bus.ledrdata, 32'h0000003C);
    bus_op(1, 0, 1, LED_ADDR_LO, 16'h0000);
    chk("lo_keep_rd", bus.ledrdata, 32'h0000A5A5);

    // Strobes without chip select do nothing
    bus_op(0, 1, 0, LED_ADDR_LO, 16'hFFFF);
    chk("nocs_led", 32'(led_o), 32'h003CA5A5);
    chk("nocs_ack", 32'(bus.ledack), 32'h0);
    chk("nocs_rdata", bus.ledrdata, 32'h0000A5A5);

    // Simultaneous read and write: readback is the old value; back-to-back ack stays high
    bus_op(1, 1, 0, LED_ADDR_LO, 16'h1234);
    bus_op(1, 1, 1, LED_ADDR_LO, 16'h5678);
    chk("rw_rdata", bus.ledrdata, 32'h00001234);
    chk("rw_led", 32'(led_o), 32'h003C5678);
    chk("b2b_ack", 32'(bus.ledack), 32'h1);

    // Asynchronous reset between clock edges
    bus_op(1, 1, 0, LED_ADDR_LO, 16'hFFFF);
    bus_op(1, 1, 0, LED_ADDR_HI, 16'h00FF);
    bus_op(1, 0, 1, LED_ADDR_LO, 16'h0000);
    chk("full_led", 32'(led_o), 32'h00FFFFFF);
    #2;
    switrst = 1'b1;
    #1;
    chk("arst_led", 32'(led_o), 32'h0);
    chk("arst_rdata", bus.ledrdata, 32'h0);
    chk("arst_ack", 32'(bus.ledack), 32'h0);
    @(posedge ledclk);
    switrst = 1'b0;

    // Blink: counter restarted by the reset above; edge numbers counted from here
`ifdef LEDS_BLINK_EN
    blk_rd   = 32'h00000003;
    led_dark = 32'h0000000C;
`else
    blk_rd   = 32'h00000000;
    led_dark = 32'h0000000F;
`endif
    bus_op(1, 1, 0, LED_ADDR_LO, 16'h000F);
    chk("blk_e1", 32'(led_o), 32'h0000000F);
    bus_op(1, 1, 0, LED_ADDR_BLK_LO, 16'h0003);
    chk("blk_e2", 32'(led_o), 32'h0000000F);
    idle(1);
    chk("blk_e3", 32'(led_o), 32'h0000000F);
    idle(1);
    chk("blk_e4", 32'(led_o), led_dark);
    idle(3);
    chk("blk_e7", 32'(led_o), led_dark);
    idle(1);
    chk("blk_e8", 32'(led_o), 32'h0000000F);
    bus_op(1, 0, 1, LED_ADDR_BLK_LO, 16'h0000);
    chk("blk_rd_lo", bus.ledrdata, blk_rd);
    chk("blk_e9", 32'(led_o), 32'h0000000F);
    idle(3);
    chk("blk_e12", 32'(led_o), led_dark);
    bus_op(1, 0, 1, LED_ADDR_BLK_HI, 16'h0000);
    chk("blk_rd_hi", bus.ledrdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
